// File: rtl/mdu_seq.sv
// mdu_seq: sequential multiply/divide unit that owns the HI/LO register pair.
// Handles MULT/MULTU (shift-add, LSB first), DIV/DIVU (restoring, MSB first)
// and MTHI/MTLO. Optional macro MDU_EARLY_OUT_EN lets multiplies leave CALC
// once no set multiplier bits remain.
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               div_q, div_d;
  logic               neg_q, neg_d;
  logic               sa_q, sa_d;
  logic               divz_q, divz_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  // Operand decode at start: signed ops take two's-complement magnitudes.
  logic             sgn_a, sgn_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  assign sgn_a = ~op[0] & a[WIDTH-1];
  assign sgn_b = ~op[0] & b[WIDTH-1];
  assign mag_a = sgn_a ? -a : a;
  assign mag_b = sgn_b ? -b : b;

  // Restoring-divide step: acc holds {remainder, dividend/quotient}.
  logic [WIDTH:0]   trial, diff;
  logic             trial_ge;
  logic [WIDTH-1:0] rem_nxt;
  assign trial    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign diff     = trial - {1'b0, mplier_q};
  assign trial_ge = (trial >= {1'b0, mplier_q});
  assign rem_nxt  = trial_ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

  // Sign fix-up of the finished result.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix, a_fix;
  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quot_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign a_fix    = sa_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

  logic last_bit;
`ifdef MDU_EARLY_OUT_EN
  // Multiply may stop once the remaining multiplier bits are all zero.
  assign last_bit = (cnt_q == '0) || (!div_q && (mplier_q[WIDTH-1:1] == '0));
`else
  assign last_bit = (cnt_q == '0);
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    neg_d    = neg_q;
    sa_d     = sa_q;
    divz_d   = divz_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          div_d    = op[1];
          neg_d    = sgn_a ^ sgn_b;
          sa_d     = sgn_a;
          divz_d   = op[1] && (b == '0);
          cnt_d    = CW'(WIDTH - 1);
          mplier_d = mag_b;
          if (op[1]) begin
            acc_d   = {{WIDTH{1'b0}}, mag_a};
            mcand_d = '0;
          end else begin
            acc_d   = '0;
            mcand_d = {{WIDTH{1'b0}}, mag_a};
          end
          state_d = (op[1] && (b == '0)) ? S_FIX : S_CALC;
        end else if (!start) begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      S_CALC: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          if (div_q) begin
            acc_d = {rem_nxt, acc_q[WIDTH-2:0], trial_ge};
          end else begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
          end
          cnt_d = cnt_q - CW'(1);
          if (last_bit) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          if (divz_q) begin
            hi_d = a_fix;
            lo_d = '1;
          end else if (div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      neg_q    <= 1'b0;
      sa_q     <= 1'b0;
      divz_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      neg_q    <= neg_d;
      sa_q     <= sa_d;
      divz_q   <= divz_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
